rom_fetch_unit: RTL and testbench

Instruction-fetch reader for the synchronous program ROM (16-bit address in, 16-bit q out, read data available one clock after the address is sampled).
- Owns the PC and issues one ROM read per cycle when it has buffer credit.
- Tracks in-flight reads and pushes returned words into a small prefetch FIFO.
- Presents the FIFO to the decode stage over a valid/ready handshake.
- Supports PC redirect (branch/jump) with flush of all stale data.

---
 rtl/rom_fetch_unit_if.sv | 25 ++
 rtl/rom_fetch_unit.sv | 125 ++++++++++++
 tb/tb_rom_fetch_unit.sv | 211 +++++++++++++++++++++
 3 files changed

// File: rtl/rom_fetch_unit_if.sv
// Decode-side instruction handshake of the ROM fetch unit.
// Master presents the FIFO head; slave (decode) returns ready.
interface rom_fetch_unit_if #(
   parameter int ADDR_W = 16,
   parameter int DATA_W = 16
);
   logic              instr_valid;
   logic [DATA_W-1:0] instr_data;
   logic [ADDR_W-1:0] instr_pc;
   logic              instr_ready;

   modport master (
      output instr_valid,
      output instr_data,
      output instr_pc,
      input  instr_ready
   );

   modport slave (
      input  instr_valid,
      input  instr_data,
      input  instr_pc,
      output instr_ready
   );
endinterface

// File: rtl/rom_fetch_unit.sv
// Program-ROM fetch unit: PC, in-flight tracking, prefetch FIFO, redirect.
// Define ROM_OUTREG_EN for a ROM with registered output (read latency 2).
module rom_fetch_unit #(
   parameter int ADDR_W     = 16,
   parameter int DATA_W     = 16,
   parameter int FIFO_DEPTH = 4,
   parameter int RESET_PC   = 0
) (
   input  logic               clk,
   input  logic               rst_n,
   output logic [ADDR_W-1:0]  rom_address,
   input  logic [DATA_W-1:0]  rom_q,
   input  logic               redirect_valid,
   input  logic [ADDR_W-1:0]  redirect_pc,
   rom_fetch_unit_if.master   dec,
   output logic [15:0]        fetch_count
);

`ifdef ROM_OUTREG_EN
   localparam int LAT = 2;
`else
   localparam int LAT = 1;
`endif
   localparam int PW = $clog2(FIFO_DEPTH);
   localparam int CW = PW + 1;

   logic [ADDR_W-1:0] r_pc;
   logic [LAT-1:0]    r_ifv;
   logic [ADDR_W-1:0] r_iftag [LAT];

   logic [DATA_W-1:0] r_mem_d [FIFO_DEPTH];
   logic [ADDR_W-1:0] r_mem_a [FIFO_DEPTH];
   logic [PW-1:0]     r_wptr;
   logic [PW-1:0]     r_rptr;
   logic [CW-1:0]     r_count;
   logic [DATA_W-1:0] r_last_d;
   logic [ADDR_W-1:0] r_last_a;
   logic [15:0]       r_fcnt;

   logic [CW:0]       w_nif;
   logic [CW:0]       w_used;
   logic              w_issue;
   logic              w_push;
   logic              w_pop;
   logic              w_valid;

   // Credit covers words already buffered plus reads still in flight.
   always_comb begin
      w_nif = '0;
      for (int i = 0; i < LAT; i++) begin
         w_nif = w_nif + {{CW{1'b0}}, r_ifv[i]};
      end
      w_used  = {1'b0, r_count} + w_nif;
      w_issue = !redirect_valid && (w_used < (CW+1)'(FIFO_DEPTH));
      w_valid = (r_count != '0);
      w_push  = r_ifv[LAT-1];
      w_pop   = w_valid && dec.instr_ready;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_pc  <= ADDR_W'(RESET_PC);
         r_ifv <= '0;
         for (int i = 0; i < LAT; i++) r_iftag[i] <= '0;
      end else if (redirect_valid) begin
         r_pc  <= redirect_pc;
         r_ifv <= '0;
      end else begin
         if (w_issue) r_pc <= r_pc + 1'b1;
         r_ifv[0]   <= w_issue;
         r_iftag[0] <= r_pc;
         for (int i = 1; i < LAT; i++) begin
            r_ifv[i]   <= r_ifv[i-1];
            r_iftag[i] <= r_iftag[i-1];
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wptr  <= '0;
         r_rptr  <= '0;
         r_count <= '0;
         for (int i = 0; i < FIFO_DEPTH; i++) begin
            r_mem_d[i] <= '0;
            r_mem_a[i] <= '0;
         end
      end else if (redirect_valid) begin
         r_wptr  <= '0;
         r_rptr  <= '0;
         r_count <= '0;
      end else begin
         if (w_push) begin
            r_mem_d[r_wptr] <= rom_q;
            r_mem_a[r_wptr] <= r_iftag[LAT-1];
            r_wptr          <= r_wptr + 1'b1;
         end
         if (w_pop) r_rptr <= r_rptr + 1'b1;
         if (w_push && !w_pop) r_count <= r_count + 1'b1;
         else if (!w_push && w_pop) r_count <= r_count - 1'b1;
      end
   end

   // Remember the last shown head so outputs hold while the FIFO is empty.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_last_d <= '0;
         r_last_a <= '0;
         r_fcnt   <= '0;
      end else begin
         if (w_valid) begin
            r_last_d <= r_mem_d[r_rptr];
            r_last_a <= r_mem_a[r_rptr];
         end
         if (!redirect_valid && w_pop) r_fcnt <= r_fcnt + 16'd1;
      end
   end

   assign rom_address     = r_pc;
   assign dec.instr_valid = w_valid;
   assign dec.instr_data  = w_valid ? r_mem_d[r_rptr] : r_last_d;
   assign dec.instr_pc    = w_valid ? r_mem_a[r_rptr] : r_last_a;
   assign fetch_count     = r_fcnt;

endmodule

// File: tb/tb_rom_fetch_unit.sv
// Scoreboard bench for rom_fetch_unit with a behavioural ROM model.
// ROM word[i] = i + 0x1000; latency follows ROM_OUTREG_EN.
module tb_rom_fetch_unit;

`ifdef ROM_OUTREG_EN
   localparam int LAT = 2;
`else
   localparam int LAT = 1;
`endif

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [15:0] rom_address;
   logic [15:0] rom_q;
   logic        redirect_valid = 1'b0;
   logic [15:0] redirect_pc = '0;
   logic [15:0] fetch_count;

   rom_fetch_unit_if #(.ADDR_W(16), .DATA_W(16)) ifc ();

   rom_fetch_unit dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .rom_address    (rom_address),
      .rom_q          (rom_q),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .dec            (ifc),
      .fetch_count    (fetch_count)
   );

   always #5 clk = ~clk;

   logic [15:0] r_q0;
   always @(posedge clk) r_q0 <= rom_address + 16'h1000;
`ifdef ROM_OUTREG_EN
   logic [15:0] r_q1;
   always @(posedge clk) r_q1 <= r_q0;
   assign rom_q = r_q1;
`else
   assign rom_q = r_q0;
`endif

   int n_vec = 0;
   int n_err = 0;
   int n_acc = 0;
   logic [31:0] sb [$];

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   always @(negedge clk) begin
      if (rst_n && ifc.instr_valid && ifc.instr_ready && !redirect_valid) begin
         logic [31:0] e;
         n_acc++;
         if (sb.size() == 0) begin
            chk("sb_extra_pc", 32'(ifc.instr_pc), 32'h1_0000);
         end else begin
            e = sb.pop_front();
            chk("pc", 32'(ifc.instr_pc), 32'(e[31:16]));
            chk("data", 32'(ifc.instr_data), 32'(e[15:0]));
         end
      end
   end

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic exp_run(input logic [15:0] start, input int n);
      logic [15:0] a;
      for (int i = 0; i < n; i++) begin
         a = start + 16'(i);
         sb.push_back({a, a + 16'h1000});
      end
   endtask

   task automatic enter_reset(input logic rdy);
      rst_n = 1'b0;
      redirect_valid = 1'b0;
      ifc.instr_ready = rdy;
      sb.delete();
      n_acc = 0;
      tick(2);
   endtask

   task automatic release_reset();
      @(negedge clk);
      #1;
      rst_n = 1'b1;
   endtask

   task automatic redirect(input logic [15:0] a);
      redirect_valid = 1'b1;
      redirect_pc = a;
      sb.delete();
      tick(1);
      redirect_valid = 1'b0;
   endtask

   task automatic drain();
      int c = 0;
      ifc.instr_ready = 1'b1;
      while (sb.size() != 0 && c < 300) begin
         tick(1);
         c++;
      end
      chk("drain_left", 32'(sb.size()), 32'd0);
      ifc.instr_ready = 1'b0;
      tick(1);
      chk("fcnt", 32'(fetch_count), 32'(n_acc));
   endtask

   initial begin
      int e;
      ifc.instr_ready = 1'b0;

      // Reset state, first-valid latency, streaming
      enter_reset(1'b1);
      chk("rst_valid", 32'(ifc.instr_valid), 32'd0);
      chk("rst_data", 32'(ifc.instr_data), 32'd0);
      chk("rst_pc", 32'(ifc.instr_pc), 32'd0);
      chk("rst_addr", 32'(rom_address), 32'd0);
      chk("rst_fcnt", 32'(fetch_count), 32'd0);
      exp_run(16'h0000, 6);
      release_reset();
      e = 0;
      while (!ifc.instr_valid && e < 10) begin
         @(posedge clk);
         e++;
         #1;
      end
      chk("first_valid_edge", 32'(e), 32'(LAT + 1));
      drain();
      chk("fcnt6", 32'(fetch_count), 32'd6);

      // Back-pressure: FIFO caps at four entries
      enter_reset(1'b0);
      release_reset();
      tick(10);
      chk("stall_addr", 32'(rom_address), 32'h0004);
      chk("stall_valid", 32'(ifc.instr_valid), 32'd1);
      chk("stall_head", 32'(ifc.instr_data), 32'h1000);
      tick(3);
      chk("stall_addr2", 32'(rom_address), 32'h0004);
      exp_run(16'h0000, 8);
      drain();

      // Redirect with full-ish FIFO and a read in flight
      enter_reset(1'b0);
      release_reset();
      tick(4);
      redirect(16'h0100);
      chk("flush_valid", 32'(ifc.instr_valid), 32'd0);
      chk("redir_addr", 32'(rom_address), 32'h0100);
      exp_run(16'h0100, 6);
      drain();

      // Address wrap
      redirect(16'hFFFE);
      exp_run(16'hFFFE, 4);
      drain();

      // Back-to-back redirects: last wins
      redirect_valid = 1'b1;
      redirect_pc = 16'h0200;
      sb.delete();
      ifc.instr_ready = 1'b1;
      tick(1);
      redirect_pc = 16'h0300;
      tick(1);
      redirect_valid = 1'b0;
      chk("b2b_addr", 32'(rom_address), 32'h0300);
      exp_run(16'h0300, 5);
      drain();

      // Asynchronous reset mid-stream
      redirect(16'h0050);
      exp_run(16'h0050, 40);
      ifc.instr_ready = 1'b1;
      tick(6);
      @(posedge clk);
      #3;
      rst_n = 1'b0;
      sb.delete();
      #1;
      chk("arst_valid", 32'(ifc.instr_valid), 32'd0);
      chk("arst_data", 32'(ifc.instr_data), 32'd0);
      chk("arst_pc", 32'(ifc.instr_pc), 32'd0);
      chk("arst_addr", 32'(rom_address), 32'd0);
      chk("arst_fcnt", 32'(fetch_count), 32'd0);
      n_acc = 0;
      tick(2);
      exp_run(16'h0000, 5);
      release_reset();
      drain();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
